vertex_transform: RTL and testbench

VERTEX_TRANSFORM -- requirements
Module: vertex_transform

---
 rtl/gfx_pkg.sv | 33 +++
 rtl/fxp_add.sv | 30 +++
 rtl/fxp_div.sv | 57 +++++
 rtl/fxp_mul.sv | 38 +++
 rtl/vt_dot4.sv | 53 +++++
 rtl/vertex_transform.sv | 207 ++++++++++++++++++++
 tb/tb_vertex_transform.sv | 290 +++++++++++++++++++++++++++++
 7 files changed

// File: rtl/gfx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gfx_pkg
// Description : Shared definitions for the vertex transform block: default
//               fixed-point and screen geometry, the fixed-point ONE constant
//               and the transform FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package gfx_pkg;

    localparam int DEF_WI    = 8;
    localparam int DEF_WF    = 8;
    localparam int DEF_SCR_W = 640;
    localparam int DEF_SCR_H = 480;

    // 1.0 in the default fixed-point format
    localparam int ONE = 1 << DEF_WF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        MAP  = 3'd3,
        OUT  = 3'd4
    } vt_state_e;

    // 1.0 for an arbitrary fraction width
    function automatic int fxp_one(input int wf);
        return (wf == DEF_WF) ? ONE : (1 << wf);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fxp_add.sv
`default_nettype none
// ============================================================================
// Module      : fxp_add
// Description : Signed fixed-point add, saturating.
// Ports       : a, b (in)  - operands, WI.WF two's complement
//               y    (out) - saturated sum
//               sat  (out) - result was clamped
// Revision    : 1.0 - initial release
// ============================================================================
module fxp_add #(
    parameter int WI = 8,
    parameter int WF = 8
) (
    input  logic signed [WI+WF-1:0] a,
    input  logic signed [WI+WF-1:0] b,
    output logic        [WI+WF-1:0] y,
    output logic                    sat
);
    localparam int W = WI + WF;
    localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    logic [W:0] sum;

    assign sum = {a[W-1], a} + {b[W-1], b};
    assign sat = sum[W] ^ sum[W-1];
    assign y   = sat ? (sum[W] ? MINV : MAXV) : sum[W-1:0];

endmodule
`default_nettype wire

// File: rtl/fxp_div.sv
`default_nettype none
// ============================================================================
// Module      : fxp_div
// Description : Signed fixed-point divide a/b, rounded half away from zero,
//               saturating. Division by zero saturates toward the sign of a.
// Ports       : a    (in)  - dividend
//               b    (in)  - divisor
//               y    (out) - rounded, saturated quotient
//               sat  (out) - result was clamped or divisor was zero
// Revision    : 1.0 - initial release
// ============================================================================
module fxp_div #(
    parameter int WI = 8,
    parameter int WF = 8
) (
    input  logic signed [WI+WF-1:0] a,
    input  logic signed [WI+WF-1:0] b,
    output logic        [WI+WF-1:0] y,
    output logic                    sat
);
    localparam int W = WI + WF;
    localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    logic          a_neg;
    logic          b_neg;
    logic          q_neg;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic [W-1:0]  b_safe;
    logic [W+WF:0] num;
    logic [W+WF:0] den;
    logic [W+WF:0] q;
    logic [W+WF:0] lim;

    assign a_neg  = a[W-1];
    assign b_neg  = b[W-1];
    assign q_neg  = a_neg ^ b_neg;
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;
    // Keep the divider away from a zero divisor; sat covers that case
    assign b_safe = (b_mag == '0) ? {{(W-1){1'b0}}, 1'b1} : b_mag;

    // Magnitude division with half the divisor added for rounding
    assign num = {1'b0, a_mag, {WF{1'b0}}} + {{(WF+2){1'b0}}, b_safe[W-1:1]};
    assign den = {{(WF+1){1'b0}}, b_safe};
    assign q   = num / den;

    // Negative results may reach one step further than positive ones
    assign lim = q_neg ? {{(WF+1){1'b0}}, 1'b1, {(W-1){1'b0}}}
                       : {{(WF+2){1'b0}}, {(W-1){1'b1}}};
    assign sat = (b_mag == '0) || (q > lim);
    assign y   = sat ? (q_neg ? MINV : MAXV)
                     : (q_neg ? -q[W-1:0] : q[W-1:0]);

endmodule
`default_nettype wire

// File: rtl/fxp_mul.sv
`default_nettype none
// ============================================================================
// Module      : fxp_mul
// Description : Signed fixed-point multiply, round-half-up, saturating.
// Ports       : a, b (in)  - operands, WI.WF two's complement
//               y    (out) - rounded, saturated product
//               sat  (out) - result was clamped
// Revision    : 1.0 - initial release
// ============================================================================
module fxp_mul #(
    parameter int WI = 8,
    parameter int WF = 8
) (
    input  logic signed [WI+WF-1:0] a,
    input  logic signed [WI+WF-1:0] b,
    output logic        [WI+WF-1:0] y,
    output logic                    sat
);
    localparam int W = WI + WF;
    localparam logic signed [2*W:0] HALF = {{(2*W){1'b0}}, 1'b1} << (WF - 1);
    localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    logic signed [2*W-1:0] prod;
    logic signed [2*W:0]   rnd;
    logic signed [2*W:0]   shr;
    logic        [W+1:0]   top;

    assign prod = a * b;
    assign rnd  = {prod[2*W-1], prod} + HALF;
    assign shr  = rnd >>> WF;
    // The result fits only if every bit above the kept sign bit matches it
    assign top  = shr[2*W:W-1];
    assign sat  = !((&top) || !(|top));
    assign y    = sat ? (shr[2*W] ? MINV : MAXV) : shr[W-1:0];

endmodule
`default_nettype wire

// File: rtl/vt_dot4.sv
`default_nettype none
// ============================================================================
// Module      : vt_dot4
// Description : Combinational 4-term fixed-point dot product,
//               y = ((m0*v0 + m1*v1) + m2*v2) + m3*v3, every step saturating.
// Ports       : m   (in)  - four matrix coefficients (one row)
//               v   (in)  - four vector components
//               y   (out) - dot product
//               sat (out) - OR of every multiply and add saturation
// Revision    : 1.0 - initial release
// ============================================================================
module vt_dot4 #(
    parameter int WI = 8,
    parameter int WF = 8
) (
    input  logic [3:0][WI+WF-1:0] m,
    input  logic [3:0][WI+WF-1:0] v,
    output logic      [WI+WF-1:0] y,
    output logic                  sat
);
    localparam int W = WI + WF;

    logic [3:0][W-1:0] prod;
    logic [3:0]        mul_sat;
    logic [2:0][W-1:0] part;
    logic [2:0]        add_sat;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_mul
            fxp_mul #(.WI(WI), .WF(WF)) u_mul (
                .a   (m[i]),
                .b   (v[i]),
                .y   (prod[i]),
                .sat (mul_sat[i])
            );
        end
    endgenerate

    fxp_add #(.WI(WI), .WF(WF)) u_add0 (
        .a (prod[0]), .b (prod[1]), .y (part[0]), .sat (add_sat[0])
    );
    fxp_add #(.WI(WI), .WF(WF)) u_add1 (
        .a (part[0]), .b (prod[2]), .y (part[1]), .sat (add_sat[1])
    );
    fxp_add #(.WI(WI), .WF(WF)) u_add2 (
        .a (part[1]), .b (prod[3]), .y (part[2]), .sat (add_sat[2])
    );

    assign y   = part[2];
    assign sat = |{mul_sat, add_sat};

endmodule
`default_nettype wire

// File: rtl/vertex_transform.sv
`default_nettype none
// ============================================================================
// Module      : vertex_transform
// Description : Transforms one object-space vertex by a 4x4 MVP matrix,
//               performs the perspective divide and maps to screen pixels.
//               One vertex in flight; a single dot-product unit and a single
//               divider are time-shared across rows/components.
// Ports       : clk, rst_n          - clock, async active-low reset
//               mvp_matrix          - row-major matrix, [0..3] is row 0
//               vx, vy, vz          - vertex (w = 1.0)
//               in_valid / in_ready - input handshake
//               sx, sy              - screen coordinates
//               depth               - z_clip / w_clip
//               clipped             - w_clip <= 0, coordinates forced to 0
//               sat                 - a fixed-point step saturated
//               out_valid/out_ready - output handshake
// Revision    : 1.0 - initial release
// ============================================================================
module vertex_transform
    import gfx_pkg::*;
#(
    parameter int WI    = DEF_WI,
    parameter int WF    = DEF_WF,
    parameter int SCR_W = DEF_SCR_W,
    parameter int SCR_H = DEF_SCR_H
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0][WI+WF-1:0] mvp_matrix,
    input  logic [WI+WF-1:0]       vx,
    input  logic [WI+WF-1:0]       vy,
    input  logic [WI+WF-1:0]       vz,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [9:0]             sx,
    output logic [9:0]             sy,
    output logic [WI+WF-1:0]       depth,
    output logic                   clipped,
    output logic                   sat,
    output logic                   out_valid,
    input  logic                   out_ready
);
    localparam int           W     = WI + WF;
    localparam int           ONE_I = fxp_one(WF);
    localparam logic [W-1:0] ONE_W = W'(ONE_I);

    vt_state_e state;
    vt_state_e state_nx;

    logic [15:0][W-1:0] mat;
    logic [W-1:0]       vx_l;
    logic [W-1:0]       vy_l;
    logic [W-1:0]       vz_l;
    logic [1:0]         row_cnt;
    logic [1:0]         div_cnt;
    logic [3:0][W-1:0]  acc;      // x_c, y_c, z_c, w_c
    logic [W-1:0]       xn;
    logic [W-1:0]       yn;

    logic [3:0][W-1:0]  row_m;
    logic [3:0][W-1:0]  dot_v;
    logic [W-1:0]       dot_y;
    logic               dot_sat;
    logic               w_nonpos;
    logic [W-1:0]       div_q;
    logic               div_sat;

    logic signed [31:0] x_scaled;
    logic signed [31:0] y_scaled;
    logic signed [31:0] sx_full;
    logic signed [31:0] sy_full;
    logic [9:0]         sx_map;
    logic [9:0]         sy_map;

    // ---------------------------------------------------------------- datapath
    assign row_m[0] = mat[{row_cnt, 2'd0}];
    assign row_m[1] = mat[{row_cnt, 2'd1}];
    assign row_m[2] = mat[{row_cnt, 2'd2}];
    assign row_m[3] = mat[{row_cnt, 2'd3}];
    assign dot_v    = {ONE_W, vz_l, vy_l, vx_l};

    vt_dot4 #(.WI(WI), .WF(WF)) u_dot4 (
        .m   (row_m),
        .v   (dot_v),
        .y   (dot_y),
        .sat (dot_sat)
    );

    // Only meaningful while row 3 is on the dot product
    assign w_nonpos = dot_y[W-1] || (dot_y == '0);

    fxp_div #(.WI(WI), .WF(WF)) u_div (
        .a   (acc[div_cnt]),
        .b   (acc[3]),
        .y   (div_q),
        .sat (div_sat)
    );

    // Viewport mapping in wide exact arithmetic: the +1 / 1- offsets and the
    // scale never saturate, only the final clamp bounds the result.
    assign x_scaled = (32'($signed(xn)) + ONE_I) * SCR_W;
    assign y_scaled = (ONE_I - 32'($signed(yn))) * SCR_H;
    assign sx_full  = x_scaled >>> (WF + 1);
    assign sy_full  = y_scaled >>> (WF + 1);
    assign sx_map   = (sx_full < 0)         ? 10'd0 :
                      (sx_full > SCR_W - 1) ? 10'(SCR_W - 1) : sx_full[9:0];
    assign sy_map   = (sy_full < 0)         ? 10'd0 :
                      (sy_full > SCR_H - 1) ? 10'(SCR_H - 1) : sy_full[9:0];

    // --------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = MUL;
            end
            MUL: begin
                if (row_cnt == 2'd3) state_nx = w_nonpos ? OUT : DIV;
            end
            DIV: begin
                if (div_cnt == 2'd2) state_nx = MAP;
            end
            MAP: begin
                state_nx = OUT;
            end
            OUT: begin
                if (out_valid && out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat       <= '0;
            vx_l      <= '0;
            vy_l      <= '0;
            vz_l      <= '0;
            row_cnt   <= '0;
            div_cnt   <= '0;
            acc       <= '0;
            xn        <= '0;
            yn        <= '0;
            sx        <= '0;
            sy        <= '0;
            depth     <= '0;
            clipped   <= 1'b0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // out_valid follows OUT by one cycle and drops on the handshake
            out_valid <= (state == OUT) && !(out_valid && out_ready);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mat     <= mvp_matrix;
                        vx_l    <= vx;
                        vy_l    <= vy;
                        vz_l    <= vz;
                        row_cnt <= '0;
                        div_cnt <= '0;
                        clipped <= 1'b0;
                        sat     <= 1'b0;
                    end
                end
                MUL: begin
                    acc[row_cnt] <= dot_y;
                    sat          <= sat | dot_sat;
                    row_cnt      <= row_cnt + 2'd1;
                    if ((row_cnt == 2'd3) && w_nonpos) begin
                        clipped <= 1'b1;
                        sx      <= '0;
                        sy      <= '0;
                        depth   <= '0;
                    end
                end
                DIV: begin
                    case (div_cnt)
                        2'd0:    xn    <= div_q;
                        2'd1:    yn    <= div_q;
                        default: depth <= div_q;
                    endcase
                    sat     <= sat | div_sat;
                    div_cnt <= div_cnt + 2'd1;
                end
                MAP: begin
                    sx <= sx_map;
                    sy <= sy_map;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vertex_transform.sv
`default_nettype none
// ============================================================================
// Module      : tb_vertex_transform
// Description : Self-checking bench for vertex_transform. A fixed-point
//               reference model computes each expected result when the vertex
//               is driven; results are queued and compared at out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vertex_transform;

    localparam int WI    = 8;
    localparam int WF    = 8;
    localparam int W     = WI + WF;
    localparam int SCR_W = 640;
    localparam int SCR_H = 480;

    typedef logic [15:0][W-1:0] mat_t;
    typedef struct {
        logic [9:0]   sx;
        logic [9:0]   sy;
        logic [W-1:0] depth;
        logic         clipped;
        logic         sat;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    mat_t         mvp_matrix;
    logic [W-1:0] vx, vy, vz;
    logic         in_valid;
    logic         in_ready;
    logic [9:0]   sx, sy;
    logic [W-1:0] depth;
    logic         clipped;
    logic         sat;
    logic         out_valid;
    logic         out_ready;

    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    vertex_transform #(.WI(WI), .WF(WF), .SCR_W(SCR_W), .SCR_H(SCR_H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mvp_matrix (mvp_matrix),
        .vx         (vx),
        .vy         (vy),
        .vz         (vz),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sx         (sx),
        .sy         (sy),
        .depth      (depth),
        .clipped    (clipped),
        .sat        (sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------ reference model
    function automatic int sat16(input longint v, inout bit s);
        if (v > 32767) begin s = 1'b1; return 32767; end
        if (v < -32768) begin s = 1'b1; return -32768; end
        return int'(v);
    endfunction

    function automatic int fmul(input int a, input int b, inout bit s);
        longint p;
        p = longint'(a) * longint'(b);
        return sat16((p + 128) >>> 8, s);
    endfunction

    function automatic int fadd(input int a, input int b, inout bit s);
        return sat16(longint'(a) + longint'(b), s);
    endfunction

    function automatic int fdiv(input int a, input int b, inout bit s);
        longint na, nb, q;
        if (b == 0) begin s = 1'b1; return (a < 0) ? -32768 : 32767; end
        na = (a < 0) ? -longint'(a) : longint'(a);
        nb = (b < 0) ? -longint'(b) : longint'(b);
        q  = (na * 256 + nb / 2) / nb;
        return sat16(((a < 0) != (b < 0)) ? -q : q, s);
    endfunction

    function automatic exp_t model(input mat_t m, input int x, input int y, input int z);
        exp_t   e;
        int     v[4];
        int     c[4];
        bit     s;
        int     xn, yn, zn;
        longint tx, ty;
        v[0] = x; v[1] = y; v[2] = z; v[3] = 256;
        s = 1'b0;
        for (int r = 0; r < 4; r++) begin
            int mv[4];
            int a;
            for (int k = 0; k < 4; k++) mv[k] = int'($signed(m[4*r+k]));
            a = fadd(fmul(mv[0], v[0], s), fmul(mv[1], v[1], s), s);
            a = fadd(a, fmul(mv[2], v[2], s), s);
            a = fadd(a, fmul(mv[3], v[3], s), s);
            c[r] = a;
        end
        if (c[3] <= 0) begin
            e.clipped = 1'b1;
            e.sx = '0; e.sy = '0; e.depth = '0;
            e.lat = 5;
        end else begin
            xn = fdiv(c[0], c[3], s);
            yn = fdiv(c[1], c[3], s);
            zn = fdiv(c[2], c[3], s);
            tx = ((longint'(xn) + 256) * SCR_W) >>> 9;
            ty = ((256 - longint'(yn)) * SCR_H) >>> 9;
            if (tx < 0) tx = 0;
            if (tx > SCR_W - 1) tx = SCR_W - 1;
            if (ty < 0) ty = 0;
            if (ty > SCR_H - 1) ty = SCR_H - 1;
            e.clipped = 1'b0;
            e.sx = 10'(tx); e.sy = 10'(ty); e.depth = 16'(zn);
            e.lat = 9;
        end
        e.sat = s;
        return e;
    endfunction

    // -------------------------------------------------------------- drivers
    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input mat_t m, input int x, input int y, input int z,
                        output int waited);
        sb.push_back(model(m, x, y, z));
        mvp_matrix = m;
        vx = 16'(x); vy = 16'(y); vz = 16'(z);
        in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("accept", in_ready, 1);
        @(negedge clk);
        acc_cyc = cyc;
        in_valid = 1'b0;
        mvp_matrix = {16{16'hA5C3}};
        vx = 16'h7777; vy = 16'h8888; vz = 16'h9999;
    endtask

    task automatic collect(input bit hold);
        exp_t e;
        int   guard;
        guard = 0;
        while (!out_valid && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        check("out_valid_seen", out_valid, 1);
        check("scoreboard_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("latency", cyc - acc_cyc, e.lat);
            check("sx", sx, e.sx);
            check("sy", sy, e.sy);
            check("depth", depth, e.depth);
            check("clipped", clipped, e.clipped);
            check("sat", sat, e.sat);
            check("in_ready_in_out", in_ready, 0);
            if (hold) begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    check("hold", {out_valid, in_ready, clipped, sat, sx, sy, depth},
                          {1'b1, 1'b0, e.clipped, e.sat, e.sx, e.sy, e.depth});
                end
                out_ready = 1'b1;
            end
        end
        @(negedge clk);
        check("in_ready_after", in_ready, 1);
        check("out_valid_drop", out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    // ------------------------------------------------------------- stimulus
    initial begin
        mat_t ident, m;
        int   waited, seen;
        exp_t dropped;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        mvp_matrix = '0; vx = '0; vy = '0; vz = '0;
        ident = '0;
        ident[0] = 16'h0100; ident[5] = 16'h0100; ident[10] = 16'h0100; ident[15] = 16'h0100;

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", {sx, sy, depth, clipped, sat}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Origin maps to screen centre
        send(ident, 0, 0, 0, waited);
        collect(1'b0);

        // x_n = 1.0 clamps to the right edge, y_n = 1.0 maps to row 0
        send(ident, 256, 256, 128, waited);
        collect(1'b0);

        // Perspective: w = z
        m = ident; m[14] = 16'h0100; m[15] = 16'h0000;
        send(m, 256, 0, 512, waited);
        collect(1'b0);

        // Negative w -> clipped short path
        m = ident; m[15] = 16'hFF00;
        send(m, 256, 256, 256, waited);
        collect(1'b0);

        // Saturating row 0
        m = ident; m[0] = 16'h7F00; m[1] = 16'h7F00; m[2] = 16'h7F00; m[3] = 16'h7F00;
        send(m, 32512, 32512, 32512, waited);
        collect(1'b0);

        // Divider overflow: w = 1/256
        m = ident; m[15] = 16'h0001;
        send(m, 256, 0, 0, waited);
        collect(1'b0);

        // Downstream stall, then a back-to-back vertex
        out_ready = 1'b0;
        send(ident, -128, 64, 32, waited);
        collect(1'b1);
        send(ident, 100, -100, 50, waited);
        check("b2b_wait", waited, 0);
        collect(1'b0);

        // Random small matrices and vertices
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 16; k++) m[k] = 16'(int'($urandom_range(0, 1024)) - 512);
            m[15] = 16'(int'($urandom_range(0, 512)) - 128);
            send(m, int'($urandom_range(0, 2048)) - 1024, int'($urandom_range(0, 2048)) - 1024,
                 int'($urandom_range(0, 2048)) - 1024, waited);
            collect(1'b0);
        end

        // Reset while the divider is working
        send(ident, 64, 64, 64, waited);
        repeat (5) @(negedge clk);
        check("pre_rst_in_ready", in_ready, 0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_in_ready", in_ready, 1);
        check("rst_async_out_valid", out_valid, 0);
        check("rst_async_outputs", {sx, sy, depth, clipped, sat}, 0);
        dropped = sb.pop_front();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_out_after_rst", seen, 0);
        send(ident, -256, -256, -64, waited);
        collect(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
